// File: rtl/board_scan_if.sv
// board_scan_if
//   Beat stream carrying one board cell per handshake from board_scan to
//   the display/status stage.
//   out_valid : beat present (producer -> consumer)
//   out_ready : consumer accepts the beat (consumer -> producer)
//   out_cell  : cell index 0..15
//   out_val   : snapshot user value of the cell
//   out_fixed : snapshot fixed-clue bit of the cell
//   out_err   : cell holds a non-empty value that differs from the solution
interface board_scan_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_cell;
    logic [2:0] out_val;
    logic       out_fixed;
    logic       out_err;

    modport master (
        output out_valid,
        output out_cell,
        output out_val,
        output out_fixed,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_cell,
        input  out_val,
        input  out_fixed,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/board_scan.sv
// board_scan
//   Snapshots the 4x4 user board, solution board and fixed mask on a start
//   request, streams one beat per cell (0..15) and then publishes a summary
//   of empty cells, wrong cells and a complete flag.
// Ports
//   clka        : clock, all state changes on the rising edge
//   restart     : asynchronous active-high reset
//   start       : scan request, honoured only when idle
//   user_board  : 16 x 3-bit user values, cell i at [3i+2:3i]
//   real_board  : 16 x 3-bit solution values, same packing
//   fill_flag   : bit i set when cell i is a given clue
//   scan_if     : beat stream (master side)
//   busy        : scan in progress (any state other than idle)
//   done        : one-cycle pulse at scan end
//   empty_cnt   : empty cells in the last completed scan
//   err_cnt     : wrong cells in the last completed scan
//   complete    : last scan had no empty and no wrong cells
module board_scan (
    input  logic              clka,
    input  logic              restart,
    input  logic              start,
    input  logic [47:0]       user_board,
    input  logic [47:0]       real_board,
    input  logic [15:0]       fill_flag,
    board_scan_if.master      scan_if,
    output logic              busy,
    output logic              done,
    output logic [4:0]        empty_cnt,
    output logic [4:0]        err_cnt,
    output logic              complete
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [47:0] r_user;
    logic [47:0] r_real;
    logic [15:0] r_fill;
    logic [3:0]  r_idx;
    logic [4:0]  r_empty_run;
    logic [4:0]  r_err_run;
    logic [4:0]  r_empty_cnt;
    logic [4:0]  r_err_cnt;
    logic        r_complete;

    // Per-cell views of the snapshot so the current cell is a simple mux.
    logic [2:0]  w_user_cell [16];
    logic [2:0]  w_real_cell [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi = gi + 1) begin : g_cells
            assign w_user_cell[gi] = r_user[3*gi +: 3];
            assign w_real_cell[gi] = r_real[3*gi +: 3];
        end
    endgenerate

    logic       w_scan;
    logic       w_accept;
    logic [2:0] w_cur_val;
    logic [2:0] w_cur_real;
    logic       w_cur_fixed;
    logic       w_cur_empty;
    logic       w_cur_err;
    logic [4:0] w_empty_next;
    logic [4:0] w_err_next;

    assign w_scan      = (r_state == S_SCAN);
    assign w_accept    = w_scan && scan_if.out_ready;
    assign w_cur_val   = w_user_cell[r_idx];
    assign w_cur_real  = w_real_cell[r_idx];
    assign w_cur_fixed = r_fill[r_idx];
    assign w_cur_empty = (w_cur_val == 3'd0);
    // Illegal values 5..7 can never equal a legal solution digit, so they
    // fall out as errors without a separate range check.
    assign w_cur_err   = !w_cur_empty && (w_cur_val != w_cur_real);

    // Running totals including the beat being accepted this cycle; these
    // are what the summary registers load on the edge entering DONE.
    assign w_empty_next = r_empty_run + {4'd0, w_cur_empty};
    assign w_err_next   = r_err_run + {4'd0, w_cur_err};

    // State register
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_accept && (r_idx == 4'd15)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Snapshot, index, running counters and summary
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_user      <= '0;
            r_real      <= '0;
            r_fill      <= '0;
            r_idx       <= '0;
            r_empty_run <= '0;
            r_err_run   <= '0;
            r_empty_cnt <= '0;
            r_err_cnt   <= '0;
            r_complete  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_user      <= user_board;
                        r_real      <= real_board;
                        r_fill      <= fill_flag;
                        r_idx       <= '0;
                        r_empty_run <= '0;
                        r_err_run   <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_accept) begin
                        r_empty_run <= w_empty_next;
                        r_err_run   <= w_err_next;
                        if (r_idx == 4'd15) begin
                            r_empty_cnt <= w_empty_next;
                            r_err_cnt   <= w_err_next;
                            r_complete  <= (w_empty_next == 5'd0) && (w_err_next == 5'd0);
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Beat fields are forced to zero outside SCAN so an idle bus is quiet.
    assign scan_if.out_valid = w_scan;
    assign scan_if.out_cell  = w_scan ? r_idx : 4'd0;
    assign scan_if.out_val   = w_scan ? w_cur_val : 3'd0;
    assign scan_if.out_fixed = w_scan && w_cur_fixed;
    assign scan_if.out_err   = w_scan && w_cur_err;

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign empty_cnt = r_empty_cnt;
    assign err_cnt   = r_err_cnt;
    assign complete  = r_complete;

endmodule

// File: tb/tb_board_scan.sv
module tb_board_scan;

    logic        clka;
    logic        restart;
    logic        start;
    logic [47:0] user_board;
    logic [47:0] real_board;
    logic [15:0] fill_flag;
    logic        busy;
    logic        done;
    logic [4:0]  empty_cnt;
    logic [4:0]  err_cnt;
    logic        complete;

    board_scan_if bif ();

    board_scan dut (
        .clka       (clka),
        .restart    (restart),
        .start      (start),
        .user_board (user_board),
        .real_board (real_board),
        .fill_flag  (fill_flag),
        .scan_if    (bif),
        .busy       (busy),
        .done       (done),
        .empty_cnt  (empty_cnt),
        .err_cnt    (err_cnt),
        .complete   (complete)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int tests = 0;
    int fails = 0;

    // Valid 4x4 solution, row-major:
    //   1 2 3 4 / 3 4 1 2 / 2 1 4 3 / 4 3 2 1
    logic [2:0]  sol [16] = '{3'd1, 3'd2, 3'd3, 3'd4,
                              3'd3, 3'd4, 3'd1, 3'd2,
                              3'd2, 3'd1, 3'd4, 3'd3,
                              3'd4, 3'd3, 3'd2, 3'd1};
    logic [47:0] clean_ub;
    logic [47:0] mixed_ub;
    logic [15:0] mixed_fill;

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_valid"},     {47'd0, bif.out_valid}, 48'd0);
        chk({pfx, "_cell"},      {44'd0, bif.out_cell},  48'd0);
        chk({pfx, "_val"},       {45'd0, bif.out_val},   48'd0);
        chk({pfx, "_fixed"},     {47'd0, bif.out_fixed}, 48'd0);
        chk({pfx, "_err"},       {47'd0, bif.out_err},   48'd0);
        chk({pfx, "_busy"},      {47'd0, busy},          48'd0);
        chk({pfx, "_done"},      {47'd0, done},          48'd0);
        chk({pfx, "_empty_cnt"}, {43'd0, empty_cnt},     48'd0);
        chk({pfx, "_err_cnt"},   {43'd0, err_cnt},       48'd0);
        chk({pfx, "_complete"},  {47'd0, complete},      48'd0);
    endtask

    // Runs one scan from IDLE: pulses start, checks every beat against the
    // expected snapshot, optionally stalls one cell and optionally swaps the
    // inputs to the clean board plus pulses start while cell 4 is shown.
    task automatic do_scan(input string nm, input logic [47:0] exp_ub,
                           input logic [15:0] exp_fix, input logic [15:0] exp_err,
                           input int stall_cell, input int stall_n, input bit mid_swap,
                           input int exp_done, input logic [4:0] e_empty,
                           input logic [4:0] e_err, input logic e_comp);
        int acc;
        int cyc;
        int rem;
        bit swapped;
        logic [2:0] ev;
        acc = 0;
        rem = stall_n;
        swapped = 1'b0;
        bif.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (acc < 16 && cyc < 60) begin
            ev = exp_ub[3*acc +: 3];
            chk($sformatf("%s_valid_c%0d", nm, cyc), {47'd0, bif.out_valid}, 48'd1);
            chk($sformatf("%s_cell_c%0d", nm, cyc),  {44'd0, bif.out_cell}, {44'd0, acc[3:0]});
            chk($sformatf("%s_val_c%0d", nm, cyc),   {45'd0, bif.out_val}, {45'd0, ev});
            chk($sformatf("%s_fixed_c%0d", nm, cyc), {47'd0, bif.out_fixed}, {47'd0, exp_fix[acc]});
            chk($sformatf("%s_err_c%0d", nm, cyc),   {47'd0, bif.out_err}, {47'd0, exp_err[acc]});
            chk($sformatf("%s_busy_c%0d", nm, cyc),  {47'd0, busy}, 48'd1);
            chk($sformatf("%s_done_c%0d", nm, cyc),  {47'd0, done}, 48'd0);
            start = 1'b0;
            if (mid_swap && acc == 4 && !swapped) begin
                user_board = clean_ub;
                real_board = clean_ub;
                fill_flag  = 16'hFFFF;
                start      = 1'b1;
                swapped    = 1'b1;
            end
            if (acc == stall_cell && rem > 0) begin
                bif.out_ready = 1'b0;
                rem--;
            end else begin
                bif.out_ready = 1'b1;
                acc++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        chk({nm, "_beats"},     acc, 48'd16);
        chk({nm, "_done_cyc"},  cyc, exp_done);
        chk({nm, "_done"},      {47'd0, done}, 48'd1);
        chk({nm, "_done_busy"}, {47'd0, busy}, 48'd1);
        chk({nm, "_done_vld"},  {47'd0, bif.out_valid}, 48'd0);
        chk({nm, "_empty_cnt"}, {43'd0, empty_cnt}, {43'd0, e_empty});
        chk({nm, "_err_cnt"},   {43'd0, err_cnt},   {43'd0, e_err});
        chk({nm, "_complete"},  {47'd0, complete},  {47'd0, e_comp});
        bif.out_ready = 1'b1;
        step();
        chk({nm, "_post_done"},  {47'd0, done}, 48'd0);
        chk({nm, "_post_busy"},  {47'd0, busy}, 48'd0);
        chk({nm, "_hold_empty"}, {43'd0, empty_cnt}, {43'd0, e_empty});
        chk({nm, "_hold_err"},   {43'd0, err_cnt},   {43'd0, e_err});
        chk({nm, "_hold_comp"},  {47'd0, complete},  {47'd0, e_comp});
    endtask

    initial begin
        int guard;
        bit found;
        for (int i = 0; i < 16; i++) clean_ub[3*i +: 3] = sol[i];
        // Cells 2 and 7 empty, cell 9 wrong digit (3 vs 1), cell 12 illegal 6.
        mixed_ub = clean_ub;
        mixed_ub[3*2 +: 3]  = 3'd0;
        mixed_ub[3*7 +: 3]  = 3'd0;
        mixed_ub[3*9 +: 3]  = 3'd3;
        mixed_ub[3*12 +: 3] = 3'd6;
        mixed_fill = 16'hA5C3;

        // Reset with random inputs and start held high
        restart       = 1'b1;
        start         = 1'b1;
        user_board    = {$urandom, $urandom};
        real_board    = {$urandom, $urandom};
        fill_flag     = 16'($urandom);
        bif.out_ready = 1'b1;
        step();
        step();
        chk_zero("reset");
        restart = 1'b0;
        start   = 1'b0;
        step();
        step();
        chk("reset_idle_busy",  {47'd0, busy}, 48'd0);
        chk("reset_idle_valid", {47'd0, bif.out_valid}, 48'd0);

        // Clean board
        user_board = clean_ub;
        real_board = clean_ub;
        fill_flag  = 16'hFFFF;
        do_scan("clean", clean_ub, 16'hFFFF, 16'h0000, -1, 0, 1'b0, 17, 5'd0, 5'd0, 1'b1);

        // Mixed board
        user_board = mixed_ub;
        real_board = clean_ub;
        fill_flag  = mixed_fill;
        do_scan("mixed", mixed_ub, mixed_fill, 16'h1200, -1, 0, 1'b0, 17, 5'd2, 5'd2, 1'b0);

        // Backpressure: three stalled cycles on cell 5
        do_scan("bp", mixed_ub, mixed_fill, 16'h1200, 5, 3, 1'b0, 20, 5'd2, 5'd2, 1'b0);

        // Snapshot isolation and ignored start
        user_board = mixed_ub;
        real_board = clean_ub;
        fill_flag  = mixed_fill;
        do_scan("snap", mixed_ub, mixed_fill, 16'h1200, -1, 0, 1'b1, 17, 5'd2, 5'd2, 1'b0);
        step();
        chk("snap_no_rescan", {47'd0, busy}, 48'd0);
        do_scan("fresh", clean_ub, 16'hFFFF, 16'h0000, -1, 0, 1'b0, 17, 5'd0, 5'd0, 1'b1);

        // Reset mid-scan at cell 8
        user_board = mixed_ub;
        fill_flag  = mixed_fill;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 30) begin
            if (bif.out_valid && bif.out_cell == 4'd8) found = 1'b1;
            else begin
                step();
                guard++;
            end
        end
        chk("midrst_reach8", {47'd0, found}, 48'd1);
        restart = 1'b1;
        #1;
        chk_zero("midrst");
        step();
        restart = 1'b0;
        step();
        user_board = clean_ub;
        real_board = clean_ub;
        fill_flag  = 16'hFFFF;
        do_scan("after_rst", clean_ub, 16'hFFFF, 16'h0000, -1, 0, 1'b0, 17, 5'd0, 5'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/board_scan.md
# board_scan

Downstream reader of the Sudoku datapath's board outputs. It sits after `dp` and feeds the display/status stage. On a `start` pulse it takes a snapshot of the 4x4 user board, the solution board and the fixed-cell mask. It then emits one handshaked beat per cell, cells 0 to 15 in order, with the cell's value, fixed bit and error bit. At the end it publishes a summary: empty-cell count, wrong-cell count and a complete flag.

## Interface
- No parameters. The board is fixed at 16 cells with 3-bit values.
- `clka`  in  1  block clock; all state changes on the rising edge.
- `restart`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `user_board`  in  48  packed user board; cell i = `[3i+2:3i]`; 0 = empty, 1–4 = digit, 5–7 = illegal.
- `real_board`  in  48  packed solution board, same packing; values 1–4.
- `fill_flag`  in  16  bit i = 1 means cell i is a given clue (fixed).
- `out_ready`  in  1  consumer accepts the current beat.
- `out_valid`  out  1  beat valid.
- `out_cell`  out  4  cell index of the beat.
- `out_val`  out  3  snapshot user value of the cell.
- `out_fixed`  out  1  snapshot `fill_flag` bit of the cell.
- `out_err`  out  1  cell is wrong: `out_val` != 0 and `out_val` != real value.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse at scan end.
- `empty_cnt`  out  5  empty cells in the last completed scan (0–16).
- `err_cnt`  out  5  wrong cells in the last completed scan (0–16).
- `complete`  out  1  last scan had `empty_cnt` == 0 and `err_cnt` == 0.

## Operation
- **States:** IDLE, SCAN, DONE.
- **IDLE:**
  - On `start` = 1, capture `user_board`, `real_board` and `fill_flag` into snapshot registers.
  - Clear the index and both running counters, then go to SCAN.
- **SCAN:**
  - `out_valid` = 1; `out_cell` = idx.
  - `out_val`, `out_fixed` and `out_err` are taken from the snapshot at idx.
  - On `out_valid && out_ready`:
    - running empty counter += (val == 0);
    - running error counter += `out_err`;
    - if idx == 15, go to DONE; otherwise idx += 1.
- **DONE:**
  - `done` = 1 for exactly one cycle.
  - `empty_cnt`, `err_cnt` and `complete` are loaded from the running counters on the edge entering DONE.
  - Return to IDLE on the next edge.
- **Error rule:** an illegal value (5–7) is always an error and never counts as empty. An empty cell is never an error. `fill_flag` does not affect counting.
- **Counter width:** both counters are 5 bits. The maximum is 16, so they never wrap.
- **Snapshot isolation:** input board changes after capture have no effect on the scan in progress.
- **`start` outside IDLE:** ignored in SCAN and DONE. It is not queued.
- **Summary outputs:** held from the DONE cycle until the next scan's DONE, or until reset.

## Timing
- **Reset values (`restart` = 1):** every output 0, state IDLE, snapshot and counters 0. Reset takes effect immediately and asynchronously, including mid-scan; any partial scan is discarded.
- **`start`:** sampled on edge t. `busy` and `out_valid` are high from cycle t+1, and the first beat (cell 0) is presented in t+1.
- **Throughput:** one beat per cycle with `out_ready` held at 1.
  - Beats occupy cycles t+1..t+16.
  - `done` is high in cycle t+17; `busy` is high t+1..t+17 and low at t+18.
  - The next `start` is accepted at the t+18 edge at the earliest.
- **Backpressure:** while `out_valid` = 1 and `out_ready` = 0, `out_cell`, `out_val`, `out_fixed` and `out_err` are held stable. `out_valid` never drops before acceptance.
- **Combinational paths:** `out_ready` is not combinationally used by any output. All outputs are registered or decoded from registers.

## Test plan
- **Reset:** assert `restart` with random inputs and `start` = 1 → all outputs 0. Deassert with `start` = 0 → stays IDLE, `busy` = 0.
- **Clean board:** `user_board` = `real_board` = valid solution, `fill_flag` = 16'hFFFF, `out_ready` = 1, `start` at t → 16 beats with `out_cell` 0..15 in cycles t+1..t+16, `out_fixed` = 1 and `out_err` = 0 on all beats. `done` in t+17 with `empty_cnt` = 0, `err_cnt` = 0, `complete` = 1.
- **Mixed board:**
  - Set cells 2 and 7 to 0, cell 9 to user 3 / real 1, cell 12 to user 6.
  - Expect `out_err` = 1 only on beats 9 and 12.
  - Expect `empty_cnt` = 2, `err_cnt` = 2, `complete` = 0.
- **Backpressure:** drop `out_ready` for 3 cycles while cell 5 is presented → `out_cell` = 5 and its data are held for 4 cycles. Exactly 16 accepted beats; `done` arrives 3 cycles later than in the unstalled case; counts are unchanged.
- **Snapshot and ignored `start`:**
  - Scan the mixed board.
  - At beat 4, change all inputs to a clean board and pulse `start` → beats and summary still match the mixed board, and no second scan occurs.
  - A fresh `start` after `done` → summary for the clean board.
- **Reset mid-scan:** assert `restart` while `out_cell` = 8 → all outputs 0 immediately, prior summary cleared. A subsequent `start` performs a full 16-beat scan from cell 0.
